// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demultiplexer: each accepted beat is steered by sel_i into a
// per-channel 2-entry FIFO, so a stalled channel never blocks the other one.

module stream_demux_1to2_fifo2 #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_push,
    input  logic [BIT_WIDTH-1:0] i_data,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [BIT_WIDTH-1:0] o_data,
    output logic [1:0]           o_count,
    output logic [15:0]          o_beats
);

    logic [BIT_WIDTH-1:0] r_mem [2];
    logic                 r_head;
    logic                 r_tail;
    logic [1:0]           r_count;
    logic [15:0]          r_beats;
    logic                 w_pop;

    always_comb begin
        o_valid = (r_count != 2'd0);
        o_data  = r_mem[r_head];
        o_count = r_count;
        o_beats = r_beats;
        w_pop   = o_valid && i_ready;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_count  <= '0;
            r_beats  <= '0;
        end else begin
            // The parent never pushes at count 2, so push+pop only occurs at count 1.
            if (i_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head  <= ~r_head;
                r_beats <= r_beats + 16'd1;
            end
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

module stream_demux_1to2 #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 sel_i,
    input  logic [BIT_WIDTH-1:0] data_i,
    output logic                 a_valid_o,
    input  logic                 a_ready_i,
    output logic [BIT_WIDTH-1:0] a_data_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [BIT_WIDTH-1:0] b_data_o,
    output logic [1:0]           a_count_o,
    output logic [1:0]           b_count_o,
    output logic [15:0]          a_beats_o,
    output logic [15:0]          b_beats_o
);

    logic w_accept;
    logic w_push_a;
    logic w_push_b;

    // Readiness looks only at the addressed channel's registered occupancy.
    always_comb begin
        in_ready_o = ((sel_i ? b_count_o : a_count_o) != 2'd2);
        w_accept   = in_valid_i && in_ready_o;
        w_push_a   = w_accept && !sel_i;
        w_push_b   = w_accept && sel_i;
    end

    stream_demux_1to2_fifo2 #(.BIT_WIDTH(BIT_WIDTH)) u_fifo_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push_a),
        .i_data  (data_i),
        .i_ready (a_ready_i),
        .o_valid (a_valid_o),
        .o_data  (a_data_o),
        .o_count (a_count_o),
        .o_beats (a_beats_o)
    );

    stream_demux_1to2_fifo2 #(.BIT_WIDTH(BIT_WIDTH)) u_fifo_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push_b),
        .i_data  (data_i),
        .i_ready (b_ready_i),
        .o_valid (b_valid_o),
        .o_data  (b_data_o),
        .o_count (b_count_o),
        .o_beats (b_beats_o)
    );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed and scoreboarded checks for stream_demux_1to2; inputs change and
// outputs are sampled on the falling clock edge.

module tb_stream_demux_1to2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sel;
    logic [7:0]  data;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [7:0]  a_data, b_data;
    logic [1:0]  a_count, b_count;
    logic [15:0] a_beats, b_beats;

    int n_checks = 0;
    int n_pass   = 0;

    stream_demux_1to2 #(.BIT_WIDTH(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .sel_i      (sel),
        .data_i     (data),
        .a_valid_o  (a_valid),
        .a_ready_i  (a_ready),
        .a_data_o   (a_data),
        .b_valid_o  (b_valid),
        .b_ready_i  (b_ready),
        .b_data_o   (b_data),
        .a_count_o  (a_count),
        .b_count_o  (b_count),
        .a_beats_o  (a_beats),
        .b_beats_o  (b_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        sel      = s;
        data     = d;
    endtask

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] na, nb;
    int          errs;
    int          delivered;
    int          last_cyc;
    logic [7:0]  nxt;
    logic [7:0]  exp_d;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        a_ready = 1'b0;
        b_ready = 1'b0;
        #1;
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_counts", {a_count, b_count}, 0);
        check("rst_beats", {a_beats, b_beats}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_data", {a_data, b_data}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Route: 0x11 to A, then 0x22 to B, both sinks ready.
        a_ready = 1'b1;
        b_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h11);
        #1 check("route_in_ready", in_ready, 1);
        @(negedge clk);
        check("route_a_valid", a_valid, 1);
        check("route_a_data", a_data, 8'h11);
        check("route_b_idle", b_valid, 0);
        drive(1'b1, 1'b1, 8'h22);
        @(negedge clk);
        check("route_b_valid", b_valid, 1);
        check("route_b_data", b_data, 8'h22);
        check("route_a_done", a_valid, 0);
        check("route_a_beats", a_beats, 1);
        drive(1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        check("route_b_beats", b_beats, 1);
        check("route_b_done", b_valid, 0);

        // Backpressure and full buffer on A.
        a_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hA0);
        @(negedge clk);
        check("bp_count1", a_count, 1);
        check("bp_head0", a_data, 8'hA0);
        drive(1'b1, 1'b0, 8'hA1);
        @(negedge clk);
        check("bp_count2", a_count, 2);
        drive(1'b1, 1'b0, 8'hA2);
        #1 check("bp_full_ready", in_ready, 0);
        @(negedge clk);
        check("bp_hold_count", a_count, 2);
        check("bp_hold_data", a_data, 8'hA0);
        a_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_count", a_count, 1);
        check("bp_out1", a_data, 8'hA1);
        check("bp_ready_again", in_ready, 1);
        @(negedge clk);
        check("bp_pushpop_count", a_count, 1);
        check("bp_out2", a_data, 8'hA2);
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("bp_empty", a_valid, 0);
        check("bp_a_beats", a_beats, 4);

        // No head-of-line blocking: A full, B still accepts.
        a_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hC0);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hC1);
        @(negedge clk);
        check("hol_a_full", a_count, 2);
        drive(1'b1, 1'b1, 8'h5B);
        #1 check("hol_in_ready", in_ready, 1);
        @(negedge clk);
        check("hol_b_data", {b_valid, b_data}, {1'b1, 8'h5B});
        check("hol_a_stays", a_count, 2);
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("hol_b_beats", b_beats, 2);

        // Asynchronous reset between edges with A holding two beats.
        #2 rst = 1'b1;
        #1;
        check("arst_a_valid", a_valid, 0);
        check("arst_counts", {a_count, b_count}, 0);
        check("arst_beats", {a_beats, b_beats}, 0);
        check("arst_a_data", a_data, 0);
        @(negedge clk);
        rst = 1'b0;
        a_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h77);
        @(negedge clk);
        check("arst_next_beat", {a_valid, a_data}, {1'b1, 8'h77});
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("arst_next_beats", a_beats, 1);

        // Streaming: 100 beats to B at one per cycle.
        rst = 1'b1;
        #1 rst = 1'b0;
        b_ready = 1'b1;
        errs = 0; delivered = 0; last_cyc = -1; nxt = 8'd0;
        for (int c = 0; c < 102; c++) begin
            if (b_valid) begin
                if (b_data !== nxt) errs++;
                nxt++;
                delivered++;
                last_cyc = c;
            end
            if (c < 100) drive(1'b1, 1'b1, 8'(c));
            else         drive(1'b0, 1'b0, 8'h00);
            @(negedge clk);
        end
        check("stream_order_errs", errs, 0);
        check("stream_delivered", delivered, 100);
        check("stream_last_cycle", last_cyc, 100);
        check("stream_b_beats", b_beats, 100);

        // Random traffic against a queue scoreboard.
        rst = 1'b1;
        #1 rst = 1'b0;
        errs = 0; na = '0; nb = '0;
        qa.delete();
        qb.delete();
        for (int c = 0; c < 10000; c++) begin
            if (c < 9990) begin
                drive(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
                a_ready = ($urandom_range(9) < 6);
                b_ready = ($urandom_range(9) < 6);
            end else begin
                drive(1'b0, 1'b0, 8'h00);
                a_ready = 1'b1;
                b_ready = 1'b1;
            end
            #1;
            if (a_count !== 2'(qa.size())) errs++;
            if (b_count !== 2'(qb.size())) errs++;
            if (a_valid !== (qa.size() != 0)) errs++;
            if (b_valid !== (qb.size() != 0)) errs++;
            if (in_ready !== ((sel ? qb.size() : qa.size()) != 2)) errs++;
            if (a_valid && a_ready) begin
                if (qa.size() == 0) errs++;
                else begin
                    exp_d = qa.pop_front();
                    if (a_data !== exp_d) errs++;
                end
                na++;
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) errs++;
                else begin
                    exp_d = qb.pop_front();
                    if (b_data !== exp_d) errs++;
                end
                nb++;
            end
            if (in_valid && in_ready) begin
                if (sel) qb.push_back(data);
                else     qa.push_back(data);
            end
            @(negedge clk);
        end
        check("rand_errs", errs, 0);
        check("rand_drained", qa.size() + qb.size(), 0);
        check("rand_a_beats", a_beats, na);
        check("rand_b_beats", b_beats, nb);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
